vga_sync_gen: RTL



---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_sync_counter.sv | 101 ++++++++++
 rtl/vga_sync_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA sync generator.
// Contents:
//   - default 640x480@60 timing constants and the derived line/frame totals
//   - Avalon register word addresses and CTRL/CLEAR bit positions
//   - in_window(): half-open range test used by the sync decoders
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_SYNC_ACTIVE = 0;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_FRAME  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_CLEAR  = 2'd3;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CLEAR_VB_BIT    = 0;

    // True when lo <= cnt < lo + len.
    function automatic logic in_window(input int unsigned cnt, input int unsigned lo,
                                       input int unsigned len);
        return (cnt >= lo) && (cnt < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical pixel counters with registered sync, blank and coordinate decode.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_adv               advance one pixel this clk (pix_ce gated by enable)
//   o_hs, o_vs          registered sync outputs (asserted level = SYNC_ACTIVE)
//   o_blank_n           registered, 1 inside the visible area
//   o_draw_x, o_draw_y  registered counter values, truncated to 10 bits
//   o_frame_start       one-clk pulse after the counters wrap to (0,0)
//   o_frame_wrap        combinational: this clk's advance wraps to (0,0)
//   o_vblank_set        combinational: this clk's advance lands on (0,V_VISIBLE)
//   o_in_vblank         combinational: current v count is at or past V_VISIBLE
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_adv,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_blank_n,
    output logic [9:0] o_draw_x,
    output logic [9:0] o_draw_y,
    output logic       o_frame_start,
    output logic       o_frame_wrap,
    output logic       o_vblank_set,
    output logic       o_in_vblank
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // One spare count of headroom so H_TOTAL itself is representable.
    localparam int unsigned H_W = $clog2(H_TOTAL + 1);
    localparam int unsigned V_W = $clog2(V_TOTAL + 1);
    localparam logic SYNC_LVL = (SYNC_ACTIVE != 0);

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic           r_hs;
    logic           r_vs;
    logic           r_blank_n;
    logic [9:0]     r_draw_x;
    logic [9:0]     r_draw_y;
    logic           r_frame_start;

    logic w_h_last;
    logic w_v_last;

    assign w_h_last = (32'(r_h_cnt) == H_TOTAL - 1);
    assign w_v_last = (32'(r_v_cnt) == V_TOTAL - 1);

    assign o_frame_wrap = i_adv && w_h_last && w_v_last;
    assign o_vblank_set = i_adv && w_h_last && (32'(r_v_cnt) == V_VISIBLE - 1);
    assign o_in_vblank  = (32'(r_v_cnt) >= V_VISIBLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hs          <= ~SYNC_LVL;
            r_vs          <= ~SYNC_LVL;
            r_blank_n     <= 1'b0;
            r_draw_x      <= '0;
            r_draw_y      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (i_adv) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
            // Decode of the pre-edge counters: outputs trail the counters by one clk.
            r_hs <= in_window(32'(r_h_cnt), H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_LVL : ~SYNC_LVL;
            r_vs <= in_window(32'(r_v_cnt), V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_LVL : ~SYNC_LVL;
            r_blank_n     <= (32'(r_h_cnt) < H_VISIBLE) && (32'(r_v_cnt) < V_VISIBLE);
            r_draw_x      <= 10'(r_h_cnt);
            r_draw_y      <= 10'(r_v_cnt);
            r_frame_start <= o_frame_wrap;
        end
    end

    assign o_hs          = r_hs;
    assign o_vs          = r_vs;
    assign o_blank_n     = r_blank_n;
    assign o_draw_x      = r_draw_x;
    assign o_draw_y      = r_draw_y;
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator with an Avalon-MM status/control slave.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_pix_ce              one-clk pixel enable
//   i_address, i_read, i_write, i_writedata   Avalon slave inputs
//   o_readdata            registered read mux (updates every clk, 1-clk latency)
//   o_irq                 registered vblank interrupt (vb_flag & irq_en)
//   o_hs, o_vs, o_blank_n, o_draw_x, o_draw_y, o_frame_start   timing outputs
// Registers: 0 STATUS {vb_flag, in_vblank, vs}, 1 FRAME count, 2 CTRL {irq_en, enable},
// 3 CLEAR (bit0 write clears vb_flag).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pix_ce,
    input  logic [1:0]  i_address,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [31:0] i_writedata,
    output logic [31:0] o_readdata,
    output logic        o_irq,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_blank_n,
    output logic [9:0]  o_draw_x,
    output logic [9:0]  o_draw_y,
    output logic        o_frame_start
);

    logic        r_enable;
    logic        r_irq_en;
    logic        r_vb_flag;
    logic [31:0] r_frame_cnt;
    logic        r_irq;
    logic [31:0] r_readdata;

    logic        w_adv;
    logic        w_vs;
    logic        w_frame_wrap;
    logic        w_vblank_set;
    logic        w_in_vblank;
    logic        w_clear;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Reads have no side effects and readdata is refreshed every clk.
    assign w_unused = ^{i_read, i_writedata[31:2]};

    assign w_adv   = i_pix_ce & r_enable;
    assign w_clear = i_write && (i_address == ADDR_CLEAR) && i_writedata[CLEAR_VB_BIT];

    vga_sync_counter #(
        .H_VISIBLE   (H_VISIBLE),
        .H_FRONT     (H_FRONT),
        .H_SYNC      (H_SYNC),
        .H_BACK      (H_BACK),
        .V_VISIBLE   (V_VISIBLE),
        .V_FRONT     (V_FRONT),
        .V_SYNC      (V_SYNC),
        .V_BACK      (V_BACK),
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_counter (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_adv         (w_adv),
        .o_hs          (o_hs),
        .o_vs          (w_vs),
        .o_blank_n     (o_blank_n),
        .o_draw_x      (o_draw_x),
        .o_draw_y      (o_draw_y),
        .o_frame_start (o_frame_start),
        .o_frame_wrap  (w_frame_wrap),
        .o_vblank_set  (w_vblank_set),
        .o_in_vblank   (w_in_vblank)
    );

    always_comb begin
        w_rdata = '0;
        unique case (i_address)
            ADDR_STATUS: begin
                w_rdata[0] = w_vs;
                w_rdata[1] = w_in_vblank;
                w_rdata[2] = r_vb_flag;
            end
            ADDR_FRAME: w_rdata = r_frame_cnt;
            ADDR_CTRL: begin
                w_rdata[CTRL_EN_BIT]     = r_enable;
                w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
            end
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_enable    <= 1'b1;
            r_irq_en    <= 1'b0;
            r_vb_flag   <= 1'b0;
            r_frame_cnt <= '0;
            r_irq       <= 1'b0;
            r_readdata  <= '0;
        end else begin
            if (i_write && (i_address == ADDR_CTRL)) begin
                r_enable <= i_writedata[CTRL_EN_BIT];
                r_irq_en <= i_writedata[CTRL_IRQ_EN_BIT];
            end
            // A vblank landing in the same clk as a clear keeps the flag set.
            if (w_vblank_set) begin
                r_vb_flag <= 1'b1;
            end else if (w_clear) begin
                r_vb_flag <= 1'b0;
            end
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            r_irq      <= r_vb_flag & r_irq_en;
            r_readdata <= w_rdata;
        end
    end

    assign o_vs       = w_vs;
    assign o_irq      = r_irq;
    assign o_readdata = r_readdata;

endmodule
